// File: rtl/ie_pkg.sv
// Shared types for the issue-to-execute operand stage.
// Tracker entries, operand-A select encoding, counter width.
package ie_pkg;

  localparam int STALL_CNT_W = 16;
  localparam int RD_MAX_W    = 8;

  typedef enum logic [1:0] {
    A_RS1     = 2'd0,
    A_PC      = 2'd1,
    A_ZERO    = 2'd2,
    A_RS1_ALT = 2'd3
  } a_sel_e;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                we;
    logic                is_load;
  } trk_entry_t;

  // A live producer writing a non-zero register equal to s.
  function automatic logic trk_match(
    input trk_entry_t          e,
    input logic [RD_MAX_W-1:0] s
  );
    return e.valid & e.we &
           (e.rd != '0) & (e.rd == s);
  endfunction

endpackage

// File: rtl/ie_fwd_select.sv
// Per-source forwarding mux: youngest matching producer wins,
// otherwise register-file data; x0 always reads zero.
module ie_fwd_select
  import ie_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic [REG_AW-1:0]              src_i,
  input  logic [XLEN-1:0]                rf_val_i,
  input  trk_entry_t [NUM_FWD-1:0]       trk_i,
  input  logic [NUM_FWD*XLEN-1:0]        fwd_i,
  output logic [XLEN-1:0]                val_o,
  output logic                           hit0_o
);

  logic [RD_MAX_W-1:0] src_w;
  logic [NUM_FWD-1:0]  unused_ld;

  assign src_w  = RD_MAX_W'(src_i);
  assign hit0_o = trk_match(trk_i[0], src_w);

  // Load flags only matter for hazard detection upstream.
  always_comb begin
    unused_ld = '0;
    for (int k = 0; k < NUM_FWD; k++) begin
      unused_ld[k] = trk_i[k].is_load;
    end
  end

  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    val_o = rf_val_i;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (trk_match(trk_i[k], src_w)) begin
        val_o = fwd_i[k*XLEN +: XLEN];
      end
    end
    if (src_i == '0) begin
      val_o = '0;
    end
  end

endmodule

// File: rtl/ie_operand_fwd.sv
// Issue-to-execute operand stage: operand muxing, result forwarding,
// in-flight destination tracking and one-bubble load-use stall.
module ie_operand_fwd
  import ie_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PC_W    = 11,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     id_valid,
  output logic                     id_ready,
  input  logic [REG_AW-1:0]        id_rs1,
  input  logic [REG_AW-1:0]        id_rs2,
  input  logic [XLEN-1:0]          id_rs1_val,
  input  logic [XLEN-1:0]          id_rs2_val,
  input  logic [PC_W-1:0]          id_pc,
  input  logic [XLEN-1:0]          id_imm,
  input  logic [1:0]               id_a_sel,
  input  logic                     id_b_sel,
  input  logic [REG_AW-1:0]        id_rd,
  input  logic                     id_rd_we,
  input  logic                     id_is_load,
  input  logic [NUM_FWD*XLEN-1:0]  fwd_data,
  output logic                     ie_valid,
  output logic [XLEN-1:0]          ie_op_a,
  output logic [XLEN-1:0]          ie_op_b,
  output logic [XLEN-1:0]          ie_rs2_fwd,
  output logic [REG_AW-1:0]        ie_rd,
  output logic                     ie_rd_we,
  output logic                     ie_is_load,
  output logic [STALL_CNT_W-1:0]   stall_cnt
);

  trk_entry_t [NUM_FWD-1:0] trk_q, trk_d;

  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  logic            rs1_hit0, rs2_hit0;

  a_sel_e a_sel;
  logic   use_rs1, use_pc, use_zero;
  logic   hazard, issue;
  logic   unused_trk_ld;

  logic                   valid_q, valid_d;
  logic [XLEN-1:0]        op_a_q, op_a_d;
  logic [XLEN-1:0]        op_b_q, op_b_d;
  logic [XLEN-1:0]        rs2_q, rs2_d;
  logic [REG_AW-1:0]      rd_q, rd_d;
  logic                   rd_we_q, rd_we_d;
  logic                   ld_q, ld_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  ie_fwd_select #(
    .XLEN    (XLEN),
    .REG_AW  (REG_AW),
    .NUM_FWD (NUM_FWD)
  ) u_fwd_rs1 (
    .src_i    (id_rs1),
    .rf_val_i (id_rs1_val),
    .trk_i    (trk_q),
    .fwd_i    (fwd_data),
    .val_o    (rs1_fwd),
    .hit0_o   (rs1_hit0)
  );

  ie_fwd_select #(
    .XLEN    (XLEN),
    .REG_AW  (REG_AW),
    .NUM_FWD (NUM_FWD)
  ) u_fwd_rs2 (
    .src_i    (id_rs2),
    .rf_val_i (id_rs2_val),
    .trk_i    (trk_q),
    .fwd_i    (fwd_data),
    .val_o    (rs2_fwd),
    .hit0_o   (rs2_hit0)
  );

  assign a_sel    = a_sel_e'(id_a_sel);
  assign use_pc   = (a_sel == A_PC);
  assign use_zero = (a_sel == A_ZERO);
  assign use_rs1  = (a_sel == A_RS1) |
                    (a_sel == A_RS1_ALT);

  // The oldest entry's load flag has nowhere further to go.
  assign unused_trk_ld = trk_q[NUM_FWD-1].is_load;

  // Load data is not ready until one stage past execute.
  assign hazard = id_valid & trk_q[0].is_load &
                  ((rs1_hit0 & use_rs1) | rs2_hit0);

  assign id_ready = ~hazard;
  assign issue    = id_valid & ~hazard & ~flush;

  // Operand A source select.
  always_comb begin
    op_a_d = op_a_q;
    unique case (1'b1)
      use_pc:   op_a_d = XLEN'(id_pc);
      use_zero: op_a_d = '0;
      default:  op_a_d = rs1_fwd;
    endcase
  end

  // Execute register next state; data holds without an issue.
  always_comb begin
    valid_d = issue;
    op_b_d  = op_b_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    rd_we_d = rd_we_q;
    ld_d    = ld_q;
    if (issue) begin
      op_b_d  = id_b_sel ? id_imm : rs2_fwd;
      rs2_d   = rs2_fwd;
      rd_d    = id_rd;
      rd_we_d = id_rd_we;
      ld_d    = id_is_load;
    end
  end

  // Tracker shift: entry 0 mirrors the execute register.
  always_comb begin
    trk_d = '0;
    if (!flush) begin
      if (issue) begin
        trk_d[0].valid   = 1'b1;
        trk_d[0].rd      = RD_MAX_W'(id_rd);
        trk_d[0].we      = id_rd_we;
        trk_d[0].is_load = id_is_load;
      end
      for (int k = 1; k < NUM_FWD; k++) begin
        trk_d[k] = trk_q[k-1];
      end
    end
  end

  // Saturating count of stall cycles not cancelled by flush.
  always_comb begin
    cnt_d = cnt_q;
    if (hazard && !flush && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Execute register and tracker state.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      rd_we_q <= 1'b0;
      ld_q    <= 1'b0;
      trk_q   <= '0;
    end else begin
      valid_q <= valid_d;
      if (issue) begin
        op_a_q <= op_a_d;
      end
      op_b_q  <= op_b_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      rd_we_q <= rd_we_d;
      ld_q    <= ld_d;
      trk_q   <= trk_d;
    end
  end

  // Stall statistics counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ie_valid   = valid_q;
  assign ie_op_a    = op_a_q;
  assign ie_op_b    = op_b_q;
  assign ie_rs2_fwd = rs2_q;
  assign ie_rd      = rd_q;
  assign ie_rd_we   = rd_we_q;
  assign ie_is_load = ld_q;
  assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_ie_operand_fwd.sv
// Bench for ie_operand_fwd: directed vector table, then random
// traffic against a history-based reference model.
module tb_ie_operand_fwd;

  localparam int XLEN = 32;
  localparam int PC_W = 11;
  localparam int RAW  = 5;
  localparam int NF   = 2;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              id_valid;
  logic              id_ready;
  logic [RAW-1:0]    id_rs1, id_rs2;
  logic [XLEN-1:0]   id_rs1_val, id_rs2_val;
  logic [PC_W-1:0]   id_pc;
  logic [XLEN-1:0]   id_imm;
  logic [1:0]        id_a_sel;
  logic              id_b_sel;
  logic [RAW-1:0]    id_rd;
  logic              id_rd_we;
  logic              id_is_load;
  logic [NF*XLEN-1:0] fwd_data;
  logic              ie_valid;
  logic [XLEN-1:0]   ie_op_a, ie_op_b, ie_rs2_fwd;
  logic [RAW-1:0]    ie_rd;
  logic              ie_rd_we, ie_is_load;
  logic [15:0]       stall_cnt;

  ie_operand_fwd #(
    .XLEN(XLEN), .PC_W(PC_W), .REG_AW(RAW), .NUM_FWD(NF)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
    .id_pc(id_pc), .id_imm(id_imm),
    .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .fwd_data(fwd_data),
    .ie_valid(ie_valid), .ie_op_a(ie_op_a),
    .ie_op_b(ie_op_b), .ie_rs2_fwd(ie_rs2_fwd),
    .ie_rd(ie_rd), .ie_rd_we(ie_rd_we),
    .ie_is_load(ie_is_load), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    bit v; bit [4:0] rs1; bit [4:0] rs2;
    bit [31:0] r1v; bit [31:0] r2v; bit [10:0] pc; bit [31:0] imm;
    bit [1:0] as; bit bs; bit [4:0] rd; bit we; bit ld; bit fl;
    bit [31:0] f0; bit [31:0] f1;
    bit e_rdy; bit e_v; bit [31:0] e_a; bit [31:0] e_b;
    bit [31:0] e_s; int e_cnt;
  } vec_t;

  function automatic vec_t mk(
    bit v, bit [4:0] rs1, bit [4:0] rs2, bit [31:0] r1v, bit [31:0] r2v,
    bit [10:0] pc, bit [31:0] imm, bit [1:0] as, bit bs, bit [4:0] rd,
    bit we, bit ld, bit fl, bit [31:0] f0, bit [31:0] f1,
    bit e_rdy, bit e_v, bit [31:0] e_a, bit [31:0] e_b, bit [31:0] e_s,
    int e_cnt);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.r1v = r1v; t.r2v = r2v;
    t.pc = pc; t.imm = imm; t.as = as; t.bs = bs; t.rd = rd;
    t.we = we; t.ld = ld; t.fl = fl; t.f0 = f0; t.f1 = f1;
    t.e_rdy = e_rdy; t.e_v = e_v; t.e_a = e_a; t.e_b = e_b;
    t.e_s = e_s; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic drive(vec_t t);
    id_valid = t.v; id_rs1 = t.rs1; id_rs2 = t.rs2;
    id_rs1_val = t.r1v; id_rs2_val = t.r2v;
    id_pc = t.pc; id_imm = t.imm;
    id_a_sel = t.as; id_b_sel = t.bs;
    id_rd = t.rd; id_rd_we = t.we; id_is_load = t.ld;
    flush = t.fl; fwd_data = {t.f1, t.f0};
  endtask

  // Reference model: what issued 1..NF cycles ago.
  typedef struct { bit v; bit [4:0] rd; bit we; bit ld; } hent_t;
  hent_t hist [NF];
  bit [31:0] m_a, m_b, m_s;
  bit [4:0]  m_rd;
  bit        m_we, m_ld, m_v;
  int        m_cnt;

  function automatic bit [31:0] mval(bit [4:0] s, bit [31:0] rf,
                                     bit [31:0] f0, bit [31:0] f1);
    bit [31:0] fw [NF];
    fw[0] = f0; fw[1] = f1;
    if (s == 0) return 0;
    for (int k = 0; k < NF; k++)
      if (hist[k].v && hist[k].we && hist[k].rd == s) return fw[k];
    return rf;
  endfunction

  vec_t tbl [$];
  vec_t cur;

  initial begin
    cur = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0);
    drive(cur);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ie_valid), 0);
    chk("rst_op_a", ie_op_a, 0);
    chk("rst_op_b", ie_op_b, 0);
    chk("rst_rs2f", ie_rs2_fwd, 0);
    chk("rst_cnt", 32'(stall_cnt), 0);
    chk("rst_ready", 32'(id_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    tbl.push_back(mk(1,1,0,5,0,0,3,0,1,0,0,0,0,0,0, 1,1,5,3,0,0));
    tbl.push_back(mk(1,2,0,0,0,0,0,0,1,5,1,0,0,0,0, 1,1,0,0,0,0));
    tbl.push_back(mk(1,5,0,'hdead,'h99,0,0,0,0,5,1,0,0,'h10,0, 1,1,'h10,0,0,0));
    tbl.push_back(mk(1,5,5,0,0,0,0,0,0,0,0,0,0,'h11,'h22, 1,1,'h11,'h11,'h11,0));
    tbl.push_back(mk(1,5,0,'h55,0,0,0,0,1,0,0,0,0,'h77,'h22, 1,1,'h22,0,0,0));
    tbl.push_back(mk(1,5,0,'h55,0,0,0,0,1,0,0,0,0,'h77,'h88, 1,1,'h55,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,4,0,1,6,1,1,0,0,0, 1,1,0,4,0,0));
    tbl.push_back(mk(1,6,6,1,2,0,0,0,0,7,1,0,0,'hbad,'hbad, 0,0,0,0,0,1));
    tbl.push_back(mk(1,6,6,1,2,0,0,0,0,7,1,0,0,'h44,'h33, 1,1,'h33,'h33,'h33,1));
    tbl.push_back(mk(1,0,0,0,0,0,8,0,1,0,1,1,0,0,0, 1,1,0,8,0,1));
    tbl.push_back(mk(1,0,0,'h123,'h456,0,0,0,0,0,0,0,0,'h999,'h999, 1,1,0,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,'h7ff,'hffffffff,1,1,0,0,0,0,0,0, 1,1,'h7ff,'hffffffff,0,1));
    tbl.push_back(mk(1,1,3,'h1234,'habc,0,0,2,0,0,0,0,0,0,0, 1,1,0,'habc,'habc,1));
    tbl.push_back(mk(1,4,0,'h44,0,0,0,3,1,0,0,0,0,0,0, 1,1,'h44,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,1,8,1,1,0,0,0, 1,1,0,0,0,1));
    tbl.push_back(mk(1,8,0,'h5,0,'h10,1,1,1,0,0,0,0,'hbad,0, 1,1,'h10,1,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,1,9,1,1,0,0,0, 1,1,0,0,0,1));
    tbl.push_back(mk(1,9,0,'h66,0,0,0,0,1,0,0,0,1,'hbad,'hbad, 0,0,0,0,0,1));
    tbl.push_back(mk(1,9,0,'h66,0,0,0,0,1,0,0,0,0,'hbad,'heee, 1,1,'h66,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,1,10,1,1,0,0,0, 1,1,0,0,0,1));
    tbl.push_back(mk(1,0,10,0,0,0,5,1,1,0,0,0,0,'hbad,0, 0,0,0,0,0,2));
    tbl.push_back(mk(1,0,10,0,0,0,5,1,1,0,0,0,0,'hbad,'h5a, 1,1,0,5,'h5a,2));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d_ready", i), 32'(id_ready), 32'(tbl[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 32'(ie_valid), 32'(tbl[i].e_v));
      if (tbl[i].e_v) begin
        chk($sformatf("v%0d_op_a", i), ie_op_a, tbl[i].e_a);
        chk($sformatf("v%0d_op_b", i), ie_op_b, tbl[i].e_b);
        chk($sformatf("v%0d_rs2f", i), ie_rs2_fwd, tbl[i].e_s);
      end
      chk($sformatf("v%0d_cnt", i), 32'(stall_cnt), 32'(tbl[i].e_cnt));
    end

    @(negedge clk);
    cur = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0);
    drive(cur);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    foreach (hist[k]) hist[k] = '{0, 0, 0, 0};
    m_v = 0; m_a = 0; m_b = 0; m_s = 0;
    m_rd = 0; m_we = 0; m_ld = 0; m_cnt = 0;

    for (int i = 0; i < 3000; i++) begin
      bit hz, iss;
      bit [31:0] fa, fb;
      hent_t nh;
      @(negedge clk);
      cur.v   = ($urandom_range(0, 9) < 8);
      cur.rs1 = 5'($urandom_range(0, 3));
      cur.rs2 = 5'($urandom_range(0, 3));
      cur.r1v = $urandom; cur.r2v = $urandom;
      cur.pc  = 11'($urandom); cur.imm = $urandom;
      cur.as  = 2'($urandom); cur.bs = 1'($urandom);
      cur.rd  = 5'($urandom_range(0, 3));
      cur.we  = ($urandom_range(0, 9) < 7);
      cur.ld  = ($urandom_range(0, 9) < 3);
      cur.fl  = ($urandom_range(0, 19) == 0);
      cur.f0  = $urandom; cur.f1 = $urandom;
      drive(cur);

      fa = mval(cur.rs1, cur.r1v, cur.f0, cur.f1);
      fb = mval(cur.rs2, cur.r2v, cur.f0, cur.f1);
      hz = cur.v && hist[0].v && hist[0].ld && hist[0].we &&
           hist[0].rd != 0 &&
           ((hist[0].rd == cur.rs1 && (cur.as == 0 || cur.as == 3)) ||
            hist[0].rd == cur.rs2);
      iss = cur.v && !hz && !cur.fl;

      #1;
      chk("rnd_ready", 32'(id_ready), 32'(!hz));
      @(posedge clk);
      #1;

      if (iss) begin
        m_a = (cur.as == 1) ? 32'(cur.pc) :
              (cur.as == 2) ? 32'd0 : fa;
        m_b = cur.bs ? cur.imm : fb;
        m_s = fb;
        m_rd = cur.rd; m_we = cur.we; m_ld = cur.ld;
      end
      m_v = iss;
      nh = '{iss, cur.rd, cur.we, cur.ld};
      for (int k = NF - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = iss ? nh : '{0, 0, 0, 0};
      if (cur.fl) foreach (hist[k]) hist[k] = '{0, 0, 0, 0};
      if (hz && !cur.fl && m_cnt < 65535) m_cnt++;

      chk("rnd_valid", 32'(ie_valid), 32'(m_v));
      chk("rnd_op_a", ie_op_a, m_a);
      chk("rnd_op_b", ie_op_b, m_b);
      chk("rnd_rs2f", ie_rs2_fwd, m_s);
      chk("rnd_rd", 32'(ie_rd), 32'(m_rd));
      chk("rnd_we", 32'(ie_rd_we), 32'(m_we));
      chk("rnd_ld", 32'(ie_is_load), 32'(m_ld));
      chk("rnd_cnt", 32'(stall_cnt), 32'(m_cnt));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
